rgb_to_yuv_compressor: RTL
==========================

Name: rgb_to_yuv_compressor

Overview:
- Encoder-side counterpart of the milestone-1 decompressor.
- Reads a 320x240 RGB image from SRAM and converts each pixel to YUV 4:4:4.
- Decimates U and V horizontally by 2, giving 4:2:2, and writes packed Y, U and V segments back to SRAM.
- Started by the top FSM via start; reports completion via finish. Owns the SRAM bus only while active.

Parameters:
- WIDTH, 320: pixels per row; must be a multiple of 4.
- HEIGHT, 240: rows.
- Y_BASE, 18'd0: first Y word address.
- U_BASE, 18'd38400: first U word address.
- V_BASE, 18'd57600: first V word address.
- RGB_BASE, 18'd146944: first RGB word address.

Ports:
- Clock  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-high reset.
- start  in  1  level; sampled in IDLE, starts a conversion.
- SRAM_read_data  in  16  SRAM read data; valid 2 cycles after the address is driven.
- SRAM_address  out  18  SRAM address.
- SRAM_write_data  out  16  SRAM write data.
- SRAM_we_n  out  1  active-low write enable.
- finish  out  1  one-cycle done pulse.

Behaviour:
- Reset at Clock edge with Reset=1. Outputs after reset:
  - SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, finish=0.
  - All counters cleared; state=IDLE.
  - Reset mid-operation aborts immediately; no further writes occur.
- RGB layout: 3 words per 2 pixels, in order {R0,G0}, {B0,R1}, {G1,B1}; high byte is first.
- Output packing, high byte = even/earlier sample:
  - Y word = {Y[2k], Y[2k+1]}.
  - U word = {U'[2k], U'[2k+1]}; V word is identical in form.
  - One group of 4 pixels = 6 RGB reads + 2 Y writes + 1 U write + 1 V write.
- Conversion uses 32-bit signed math and an arithmetic >>8:
  - Y = ((66R + 129G + 25B + 128) >>> 8) + 16
  - U = ((-38R - 74G + 112B + 128) >>> 8) + 128
  - V = ((112R - 94G - 18B + 128) >>> 8) + 128
  - Clip results to 0..255.
- Decimation: U'[j] = (U[2j] + U[2j+1] + 1) >> 1, with a 9-bit sum; V' uses the same rule. The +1 is removed when UV_ROUND_EN is undefined.
- States:
  - IDLE: we_n=1. On start=1, go to LEAD_IN next cycle.
  - LEAD_IN: 3 cycles. Issue the first 2 RGB read addresses to prime the 2-cycle read pipeline.
  - CC0..CC9: steady state, 10 cycles per 4-pixel group, with exactly one SRAM access per cycle. Loop to CC0 until the last group's final RGB read is issued.
  - LEAD_OUT: drain the pipeline and perform the outstanding Y/U/V writes.
  - DONE: finish=1 for exactly one cycle, then go to IDLE.
- start is ignored outside IDLE. If start is still high on return to IDLE, a new conversion begins.
- Total latency from start to finish is at most (WIDTH*HEIGHT/4)*10 + 16 cycles. For default parameters this is 192016.
- Multiplier budget: at most four 32-bit signed multipliers, time-shared across CC0..CC9.
- Address counters are independent and increment only after a transfer on their own segment:
  - RGB: RGB_BASE .. RGB_BASE + 1.5*W*H - 1.
  - Y: Y_BASE + W*H/2 words.
  - U and V: W*H/4 words each.
- The last RGB address (262143 at default) must not wrap. No access occurs outside the four segments.
- When we_n=0, SRAM_write_data is stable in the same cycle as SRAM_address.
- While idle, SRAM_address holds its last value.

Optional Feature:
- Macro UV_ROUND_EN.
- Defined: decimation rounds half up, (a+b+1)>>1.
- Undefined: decimation truncates, (a+b)>>1.
- Y conversion and the U/V +128 rounding term are unaffected either way.

Test Plan:
- All pixels R=G=B=255, start pulsed -> every Y word 0xEBEB, every U and V word 0x8080; finish is a single pulse within 192016 cycles.
- All pixels black -> Y words 0x1010, U and V words 0x8080.
- Group of 4 pixels red, red, blue, blue:
  - Y word 0 = 0x5252, Y word 1 = 0x2929.
  - U word = 0x5AF0, V word = 0xF06E.
- Pixel pair (B=3, R=G=0) then (black), followed by 2 black pixels:
  - UV_ROUND_EN defined -> U word 0x8180.
  - UV_ROUND_EN undefined -> U word 0x8080.
  - V word 0x8080 in both cases.
- Reset asserted during CC5 of group 100 -> SRAM_we_n=1 from the next edge, no writes afterward, state IDLE. A subsequent start produces a full correct image.
- start held high across DONE -> finish pulses, then a second conversion starts. Address monitor confirms no access outside the segments and the RGB read address never exceeds 262143.

Source files
------------

// File: rtl/rgb_to_yuv_compressor.sv
// Streams a packed RGB image out of SRAM, converts it to YUV and writes 4:2:2 Y, U and V segments.
// Build macro UV_ROUND_EN selects round-half-up chroma decimation; truncation otherwise.
module rgb_to_yuv_compressor #(
    parameter int          WIDTH    = 320,
    parameter int          HEIGHT   = 240,
    parameter logic [17:0] Y_BASE   = 18'd0,
    parameter logic [17:0] U_BASE   = 18'd38400,
    parameter logic [17:0] V_BASE   = 18'd57600,
    parameter logic [17:0] RGB_BASE = 18'd146944
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        start,
    input  logic [15:0] SRAM_read_data,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        finish
);
    localparam int          GROUPS     = WIDTH * HEIGHT / 4;
    localparam logic [15:0] LAST_GROUP = 16'(GROUPS - 1);
`ifdef UV_ROUND_EN
    localparam logic [8:0]  UV_RND     = 9'd1;
`else
    localparam logic [8:0]  UV_RND     = 9'd0;
`endif

    typedef enum logic [2:0] {IDLE, LEAD_IN, CC, LEAD_OUT, DONE} state_t;

    state_t             state_reg;
    logic [3:0]         step_reg;
    logic [15:0]        grp_reg;
    logic               tail_reg, res_valid_reg;
    logic [17:0]        rgb_cnt_reg, y_cnt_reg, u_cnt_reg, v_cnt_reg;
    logic [7:0]         r_reg [4], g_reg [4], b_reg [4];
    logic signed [31:0] acc_reg [12];
    logic signed [31:0] acc_next [12];
    logic [15:0]        y_word0_reg, y_word1_reg, u_word_reg, v_word_reg;

    logic               active;
    logic [3:0]         phase;
    logic signed [31:0] prod [4];
    logic [3:0]         tgt [4];
    logic [7:0]         y_pix [4], u_pix [4], v_pix [4];

    function automatic logic signed [31:0] coef(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0:    coef = 32'sd66;
            4'h1:    coef = 32'sd129;
            4'h2:    coef = 32'sd25;
            4'h4:    coef = -32'sd38;
            4'h5:    coef = -32'sd74;
            4'h6:    coef = 32'sd112;
            4'h8:    coef = 32'sd112;
            4'h9:    coef = -32'sd94;
            4'hA:    coef = -32'sd18;
            default: coef = 32'sd0;
        endcase
    endfunction

    function automatic logic [7:0] clip8(input logic signed [31:0] acc, input logic signed [31:0] off);
        logic signed [31:0] v;
        v = (acc >>> 8) + off;
        if (v < 0)        clip8 = 8'd0;
        else if (v > 255) clip8 = 8'd255;
        else              clip8 = v[7:0];
    endfunction

    function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + UV_RND;
        avg2 = s[8:1];
    endfunction

    // The 36 products of a 4-pixel group are laid out linearly (pixel, row, colour) and
    // consumed four per cycle over nine phases; phase 9 latches results and clears.
    always_comb begin
        active = (state_reg == CC) || (state_reg == LEAD_OUT);
        phase  = (step_reg >= 4'd3) ? step_reg - 4'd3 : step_reg + 4'd7;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mult
            logic [5:0]         n;
            logic [1:0]         pix, row, col;
            logic [7:0]         sample;
            logic signed [31:0] mult_a, mult_b, mult_p;
            always_comb begin
                n   = {phase, 2'b00} + 6'(gi);
                pix = 2'(n / 6'd9);
                row = 2'((n % 6'd9) / 6'd3);
                col = 2'(n % 6'd3);
                case (col)
                    2'd0:    sample = r_reg[pix];
                    2'd1:    sample = g_reg[pix];
                    default: sample = b_reg[pix];
                endcase
                mult_a = coef(row, col);
                mult_b = $signed({24'd0, sample});
                mult_p = mult_a * mult_b;
            end
            assign prod[gi] = mult_p;
            assign tgt[gi]  = {2'b00, pix} * 4'd3 + {2'b00, row};
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_pix
            assign y_pix[gi] = clip8(acc_reg[3*gi],     32'sd16);
            assign u_pix[gi] = clip8(acc_reg[3*gi + 1], 32'sd128);
            assign v_pix[gi] = clip8(acc_reg[3*gi + 2], 32'sd128);
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < 12; i++) acc_next[i] = acc_reg[i];
        for (int k = 0; k < 4; k++) acc_next[tgt[k]] = acc_next[tgt[k]] + prod[k];
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg       <= IDLE;
            step_reg        <= '0;
            grp_reg         <= '0;
            tail_reg        <= 1'b0;
            res_valid_reg   <= 1'b0;
            rgb_cnt_reg     <= '0;
            y_cnt_reg       <= '0;
            u_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            y_word0_reg     <= '0;
            y_word1_reg     <= '0;
            u_word_reg      <= '0;
            v_word_reg      <= '0;
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            finish          <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_reg[i] <= '0;
                g_reg[i] <= '0;
                b_reg[i] <= '0;
            end
            for (int i = 0; i < 12; i++) acc_reg[i] <= '0;
        end else begin
            finish    <= 1'b0;
            SRAM_we_n <= 1'b1;
            if (active) begin
                // Read data lands three steps after the issuing step.
                case (step_reg)
                    4'd1:    {r_reg[0], g_reg[0]} <= SRAM_read_data;
                    4'd2:    {b_reg[0], r_reg[1]} <= SRAM_read_data;
                    4'd3:    {g_reg[1], b_reg[1]} <= SRAM_read_data;
                    4'd4:    {r_reg[2], g_reg[2]} <= SRAM_read_data;
                    4'd5:    {b_reg[2], r_reg[3]} <= SRAM_read_data;
                    4'd6:    {g_reg[3], b_reg[3]} <= SRAM_read_data;
                    default: ;
                endcase
                if (step_reg == 4'd2) begin
                    y_word0_reg   <= {y_pix[0], y_pix[1]};
                    y_word1_reg   <= {y_pix[2], y_pix[3]};
                    u_word_reg    <= {avg2(u_pix[0], u_pix[1]), avg2(u_pix[2], u_pix[3])};
                    v_word_reg    <= {avg2(v_pix[0], v_pix[1]), avg2(v_pix[2], v_pix[3])};
                    res_valid_reg <= (state_reg == CC && grp_reg != '0) ||
                                     (state_reg == LEAD_OUT && tail_reg);
                    for (int i = 0; i < 12; i++) acc_reg[i] <= 32'sd128;
                end else begin
                    for (int i = 0; i < 12; i++) acc_reg[i] <= acc_next[i];
                end
                if (step_reg >= 4'd4 && step_reg <= 4'd7 && res_valid_reg) begin
                    SRAM_we_n <= 1'b0;
                    case (step_reg[1:0])
                        2'd0: begin
                            SRAM_address    <= Y_BASE + y_cnt_reg;
                            SRAM_write_data <= y_word0_reg;
                            y_cnt_reg       <= y_cnt_reg + 18'd1;
                        end
                        2'd1: begin
                            SRAM_address    <= Y_BASE + y_cnt_reg;
                            SRAM_write_data <= y_word1_reg;
                            y_cnt_reg       <= y_cnt_reg + 18'd1;
                        end
                        2'd2: begin
                            SRAM_address    <= U_BASE + u_cnt_reg;
                            SRAM_write_data <= u_word_reg;
                            u_cnt_reg       <= u_cnt_reg + 18'd1;
                        end
                        default: begin
                            SRAM_address    <= V_BASE + v_cnt_reg;
                            SRAM_write_data <= v_word_reg;
                            v_cnt_reg       <= v_cnt_reg + 18'd1;
                        end
                    endcase
                end
            end

            case (state_reg)
                IDLE: if (start) begin
                    state_reg     <= LEAD_IN;
                    step_reg      <= '0;
                    grp_reg       <= '0;
                    tail_reg      <= 1'b0;
                    res_valid_reg <= 1'b0;
                    rgb_cnt_reg   <= '0;
                    y_cnt_reg     <= '0;
                    u_cnt_reg     <= '0;
                    v_cnt_reg     <= '0;
                end
                LEAD_IN: begin
                    if (step_reg != 4'd0) begin
                        SRAM_address <= RGB_BASE + rgb_cnt_reg;
                        rgb_cnt_reg  <= rgb_cnt_reg + 18'd1;
                    end
                    if (step_reg == 4'd2) begin
                        state_reg <= CC;
                        step_reg  <= '0;
                    end else begin
                        step_reg <= step_reg + 4'd1;
                    end
                end
                CC: begin
                    // Steps 8/9 prefetch the next group's first two words.
                    if (step_reg <= 4'd3 || (step_reg >= 4'd8 && grp_reg != LAST_GROUP)) begin
                        SRAM_address <= RGB_BASE + rgb_cnt_reg;
                        rgb_cnt_reg  <= rgb_cnt_reg + 18'd1;
                    end
                    if (step_reg == 4'd3 && grp_reg == LAST_GROUP) begin
                        state_reg <= LEAD_OUT;
                        step_reg  <= 4'd4;
                    end else if (step_reg == 4'd9) begin
                        step_reg <= '0;
                        grp_reg  <= grp_reg + 16'd1;
                    end else begin
                        step_reg <= step_reg + 4'd1;
                    end
                end
                LEAD_OUT: begin
                    if (tail_reg && step_reg == 4'd7) begin
                        state_reg <= DONE;
                        finish    <= 1'b1;
                    end else if (step_reg == 4'd9) begin
                        step_reg <= '0;
                        tail_reg <= 1'b1;
                    end else begin
                        step_reg <= step_reg + 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
